// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, control-field enums, control bundle and state type for the decode stage
// Purpose: common types for decode_ctrl_lut, decode_stage_if and decode_stage.
// Optional feature macro: DECODE_MEXT_EN (consumed in decode_ctrl_lut).
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_BR   = 2'b01,
    ALU_FN   = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic        illegal;
    logic        muldiv;
    logic        reg_write;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        ld_src;
    logic        st_src;
    imm_src_e    imm_src;
    result_src_e result_src;
    alu_op_e     alu_op;
  } ctrl_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/execute handshake bundle of the decode stage
// Purpose: groups intake (in_*), output (out_*), flush, trap_ack and illegal_count.
// Modports: master = fetch/execute/trap side driving requests; slave = decode_stage.
interface decode_stage_if
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  ctrl_t            out_ctrl;
  logic [31:0]      out_instr;
  logic [XLEN-1:0]  out_pc;
  logic             trap_ack;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready, trap_ack,
    input  in_ready, out_valid, out_ctrl, out_instr, out_pc, illegal_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready, trap_ack,
    output in_ready, out_valid, out_ctrl, out_instr, out_pc, illegal_count
  );
endinterface

// File: rtl/decode_ctrl_lut.sv
// rtl/decode_ctrl_lut.sv - combinational RV32I main decoder, opcode/funct3/funct7 to ctrl_t
// Ports: i_opcode, i_funct3, i_funct7 in; o_ctrl out (complete bundle, illegal-only when undecodable).
// Macro DECODE_MEXT_EN: when defined, R-type funct7=0000001 decodes as legal mul/div.
module decode_ctrl_lut
  import decode_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output ctrl_t      o_ctrl
);
  ctrl_t w_ctrl;
  logic  w_bad;

  always_comb begin
    w_ctrl = '0;
    w_bad  = 1'b0;
    case (i_opcode)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_FN;
        if (i_funct7 == F7_MULDIV) begin
`ifdef DECODE_MEXT_EN
          w_ctrl.muldiv = 1'b1;
`else
          w_bad = 1'b1;
`endif
        end else if ((i_funct7 != F7_BASE) && (i_funct7 != F7_ALT)) begin
          w_bad = 1'b1;
        end
      end
      OP_IMM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.imm_src   = IMM_I;
      end
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src_b  = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_ctrl.ld_src     = i_funct3[2];
        w_bad = (i_funct3 inside {3'b011, 3'b110, 3'b111});
      end
      OP_JALR: begin
        w_ctrl.jump       = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_ctrl.alu_src_b  = 1'b1;
        w_bad = (i_funct3 != 3'b000);
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.imm_src   = IMM_S;
        w_ctrl.st_src    = ~&i_funct3;
        w_bad = (i_funct3 > 3'b010);
      end
      OP_BRANCH: begin
        w_ctrl.branch  = 1'b1;
        w_ctrl.imm_src = IMM_B;
        w_ctrl.alu_op  = ALU_BR;
        w_bad = (i_funct3 inside {3'b010, 3'b011});
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.imm_src   = IMM_U;
        w_ctrl.alu_op    = ALU_PASS;
      end
      OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.imm_src   = IMM_U;
        w_ctrl.alu_op    = ALU_PASS;
      end
      OP_JAL: begin
        w_ctrl.jump       = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_ctrl.imm_src    = IMM_J;
      end
      default: w_bad = 1'b1;
    endcase

    // An illegal entry carries no side-effect enables into execute.
    o_ctrl = w_ctrl;
    if (w_bad) begin
      o_ctrl         = '0;
      o_ctrl.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with 2-entry skid buffer and illegal-instruction trap
// Ports: clk, rst_n (async, active-low); bus (decode_stage_if.slave): in_* intake, out_* head entry,
//        flush, trap_ack, illegal_count.
// Macro DECODE_MEXT_EN selects M-extension decode inside decode_ctrl_lut.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  localparam logic [0:0] S_RUN  = ST_RUN;
  localparam logic [0:0] S_TRAP = ST_TRAP;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t           r_head;
  entry_t           r_skid;
  logic             r_head_v;
  logic             r_skid_v;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_illegal_cnt;
  logic             r_alive;

  ctrl_t  w_dec_ctrl;
  entry_t w_new;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_pop;

  decode_ctrl_lut u_lut (
    .i_opcode (bus.in_instr[6:0]),
    .i_funct3 (bus.in_instr[14:12]),
    .i_funct7 (bus.in_instr[31:25]),
    .o_ctrl   (w_dec_ctrl)
  );

  assign w_new = {w_dec_ctrl, bus.in_instr, bus.in_pc};

  // Intake depends only on registered state, so out_ready never reaches in_ready.
  // r_alive keeps intake closed while reset is held and until the first edge after release.
  assign w_in_ready = r_alive & (r_state == S_RUN) & ~r_skid_v;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_pop      = r_head_v & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_skid   <= '0;
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (bus.flush) begin
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_pop) begin
      // A full buffer blocks intake, so skid promotion never coincides with an accept.
      if (r_skid_v) begin
        r_head   <= r_skid;
        r_skid_v <= 1'b0;
      end else if (w_accept) begin
        r_head <= w_new;
      end else begin
        r_head_v <= 1'b0;
      end
    end else if (w_accept) begin
      if (r_head_v) begin
        r_skid   <= w_new;
        r_skid_v <= 1'b1;
      end else begin
        r_head   <= w_new;
        r_head_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_illegal_cnt <= '0;
    end else if (bus.flush) begin
      r_state <= S_RUN;
    end else if (r_state == S_RUN) begin
      if (w_accept && w_dec_ctrl.illegal) begin
        r_state <= S_TRAP;
        if (r_illegal_cnt != {CNT_W{1'b1}}) begin
          r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
      end
    end else if (bus.trap_ack) begin
      r_state <= S_RUN;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_head_v;
  assign bus.out_ctrl      = r_head.ctrl;
  assign bus.out_instr     = r_head.instr;
  assign bus.out_pc        = r_head.pc;
  assign bus.illegal_count = r_illegal_cnt;
endmodule
